// File: rtl/display_arbiter.sv
// display_arbiter
//
// Round-robin arbiter that merges several character producers onto the single
// write port of the seven-segment display character FIFO. A requester keeps
// its grant for a whole packet, so strings from different producers never
// interleave. FIFO-full backpressure passes straight through to the granted
// requester.
//
// Handshake: a requester presents a character with req_valid_i[k] and must
// hold valid, data and last stable until a transfer occurs. A transfer occurs
// in any cycle where req_valid_i[k] and req_ready_o[k] are both high. The
// FIFO captures fifo_data_o on the same clock edge whenever fifo_wren_o is
// high.
//
// Ports:
//   clk_i        clock
//   reset_i      asynchronous, active-high reset
//   req_valid_i  per-requester character valid              [N_REQ]
//   req_data_i   requester k's character on [8k+7:8k]       [8*N_REQ]
//   req_last_i   per-requester last-character-of-packet     [N_REQ]
//   req_ready_o  per-requester accept                       [N_REQ]
//   fifo_full_i  display FIFO full
//   fifo_wren_o  display FIFO write strobe
//   fifo_data_o  display FIFO write data                    [8]
//   grant_o      one-hot current grant, zero when idle      [N_REQ]
//   busy_o       high while a grant is held (LOCKED state)
module display_arbiter #(
  parameter int N_REQ        = 3,
  parameter int MAX_BURST    = 16,
  parameter int IDLE_TIMEOUT = 255
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic               fifo_full_i,
  output logic               fifo_wren_o,
  output logic [7:0]         fifo_data_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    burst_q, burst_d;
  logic [7:0]    idle_q, idle_d;

  // Round-robin pick: first pending requester after the last-served one.
  logic          pick_valid;
  logic [IW-1:0] pick_idx;

  always_comb begin
    int            cand;
    logic [IW-1:0] cand_idx;
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IW'(cand);
      if (!pick_valid && req_valid_i[cand_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Signals of the currently granted requester.
  logic       g_valid;
  logic       g_last;
  logic [7:0] g_data;

  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_q == IW'(k)) begin
        g_valid = req_valid_i[k];
        g_last  = req_last_i[k];
        g_data  = req_data_i[8*k +: 8];
      end
    end
  end

  logic       locked;
  logic       xfer;
  logic [7:0] burst_inc;
  logic [7:0] idle_inc;

  assign locked    = (state_q == ST_LOCKED);
  assign xfer      = locked & g_valid & ~fifo_full_i;
  assign burst_inc = burst_q + 8'd1;
  // Idle counter saturates so a long stall can never wrap back below the limit.
  assign idle_inc  = (idle_q == 8'hFF) ? idle_q : idle_q + 8'd1;

  // Outputs: everything is zero in IDLE; in LOCKED the granted requester is
  // connected straight through to the FIFO write port.
  always_comb begin
    req_ready_o = '0;
    grant_o     = '0;
    fifo_wren_o = 1'b0;
    fifo_data_o = 8'h00;
    busy_o      = locked;
    if (locked) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (grant_q == IW'(k)) begin
          grant_o[k]     = 1'b1;
          req_ready_o[k] = ~fifo_full_i;
        end
      end
      fifo_wren_o = g_valid & ~fifo_full_i;
      fifo_data_o = g_data;
    end
  end

  // Next state. Last-character and burst-limit releases share one path, so a
  // packet whose last character also hits the burst limit releases only once.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    burst_d = burst_q;
    idle_d  = idle_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_LOCKED;
          grant_d = pick_idx;
          burst_d = 8'd0;
          idle_d  = 8'd0;
        end
      end
      ST_LOCKED: begin
        if (xfer) begin
          burst_d = burst_inc;
          idle_d  = 8'd0;
          if (g_last || (burst_inc == 8'(MAX_BURST))) begin
            state_d = ST_IDLE;
            ptr_d   = grant_q;
          end
        end else begin
          idle_d = idle_inc;
          if (idle_inc == 8'(IDLE_TIMEOUT)) begin
            state_d = ST_IDLE;
            ptr_d   = grant_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ptr resets to the last requester so requester 0 wins the first grant.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ptr_q   <= IW'(N_REQ - 1);
      burst_q <= 8'd0;
      idle_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      burst_q <= burst_d;
      idle_q  <= idle_d;
    end
  end

endmodule

// File: doc/display_arbiter.md
# display_arbiter

Arbitrates several character producers onto the single write port of the seven-segment display character FIFO. Typical producers are the core's memory-mapped display register, the trap/exception reporter and the debug path. Each requester sends a packet of 8-bit characters terminated by a `last` flag. The arbiter grants one requester at a time, round-robin, and holds the grant for a whole packet so strings never interleave. FIFO-full backpressure passes straight through to the granted requester.

## Interface
Parameters:
- N_REQ, 3: number of requesters, 2..8.
- MAX_BURST, 16: maximum characters per grant before forced release, 1..255.
- IDLE_TIMEOUT, 255: consecutive granted cycles without a transfer before forced release, 1..255.

Ports (reset reset_i, asynchronous, active-high; clock clk_i):
- clk_i, in, 1: clock.
- reset_i, in, 1: asynchronous active-high reset.
- req_valid_i, in, N_REQ: per-requester character valid.
- req_data_i, in, 8*N_REQ: requester k's character on bits [8k+7:8k].
- req_last_i, in, N_REQ: current character is the packet's final one.
- req_ready_o, out, N_REQ: per-requester accept; a transfer occurs when valid and ready are both high.
- fifo_full_i, in, 1: display FIFO full.
- fifo_wren_o, out, 1: write strobe to the display FIFO (its wren_i).
- fifo_data_o, out, 8: character to the display FIFO (its data_i).
- grant_o, out, N_REQ: one-hot current grant; all zero when idle.
- busy_o, out, 1: high while the arbiter is in the LOCKED state.

## Operation
- State machine with two states: IDLE and LOCKED. Registered state: grant index, last-served pointer `ptr`, burst counter (8 bit) and idle counter (8 bit).
- **IDLE**
  - If any req_valid_i bit is set, select the first set bit searching ptr+1, ptr+2, … modulo N_REQ.
  - Register that index as the grant, go to LOCKED, and clear both counters.
  - If no request is pending, stay in IDLE.
- **LOCKED**, granted index g:
  - req_ready_o[g] = ~fifo_full_i. All other ready bits are 0.
  - fifo_wren_o = req_valid_i[g] & ~fifo_full_i.
  - fifo_data_o = req_data_i[g] (combinational pass-through).
  - On a transfer: increment the burst counter and clear the idle counter.
  - With no transfer: increment the idle counter, saturating at 255.
- **Release** from LOCKED to IDLE, with ptr <= g, occurs at the end of a cycle in which any of these holds:
  - a transfer occurs with req_last_i[g] = 1;
  - a transfer brings the burst counter to MAX_BURST;
  - the idle counter reaches IDLE_TIMEOUT.
- Outputs while in IDLE: req_ready_o = 0, fifo_wren_o = 0, fifo_data_o = 8'h00, grant_o = 0.
- **Backpressure:** while fifo_full_i = 1, no transfer occurs. Data and valid must be held by the requester. Full cycles count toward IDLE_TIMEOUT.
- **Simultaneous events:**
  - If last and burst limit coincide, the arbiter performs a single release.
  - A requester that deasserts valid mid-packet keeps the grant until its next character arrives or IDLE_TIMEOUT expires.
- A new request arriving for the currently granted requester is not served back-to-back if another requester is pending; the round-robin order decides.

## Timing
- Reset values: state IDLE, ptr = N_REQ-1 (requester 0 wins first), counters 0. All outputs 0.
- Arbitration latency: a request seen in IDLE at cycle t produces grant_o and ready in cycle t+1. The first character can be written in cycle t+1.
- Write path: zero latency, combinational. fifo_wren_o asserts in the same cycle as the handshake, and the FIFO captures on that clock edge.
- Release takes effect on the next edge. One IDLE cycle always separates consecutive grants, so the minimum inter-packet gap is 1 cycle.
- Sustained throughput within a packet: 1 character per cycle while the FIFO is not full.
- Asserting reset_i mid-packet immediately clears state and outputs. The partial packet is dropped from arbitration; characters already written stay in the FIFO.

## Test plan
- **Single requester:** requester 0 sends "HI" (8'h48, then 8'h49 with last). Required:
  - grant_o = 3'b001 one cycle after valid;
  - fifo_wren_o high for exactly 2 cycles carrying 48h then 49h;
  - busy_o drops on the edge after 49h;
  - grant_o returns to 0.
- **Round-robin:** all 3 requesters post 1-character packets every cycle. Required:
  - grant order 0,1,2,0,1,2;
  - fifo_wren_o pattern 1,0,1,0,… (one IDLE cycle between packets).
- **Backpressure:** requester 1 sends a 4-character packet; fifo_full_i = 1 during the second character for 5 cycles. Required:
  - no fifo_wren_o during the full window;
  - req_ready_o[1] = 0 during the window;
  - all 4 characters written in order;
  - no timeout, since 5 < IDLE_TIMEOUT.
- **Burst limit:** MAX_BURST = 4; requester 2 streams 10 characters with no last, and requester 0 is waiting. Required:
  - release after the 4th write;
  - requester 0 granted next;
  - requester 2 regains the grant only after requester 0's packet completes.
- **Idle timeout:** IDLE_TIMEOUT = 8; requester 0 sends 1 character without last, then drops valid. Required: busy_o falls on the edge after 8 transfer-less cycles and grant_o = 0.
- **Reset mid-packet:** assert reset_i during the second of 3 characters. Required:
  - all outputs 0 immediately;
  - after reset the next grant goes to requester 0.
